io_bus_ctl: RTL and testbench

- Sequences Z80 I/O cycles from the tv80 core onto up to NDEV testbench I/O devices over a req/ack device bus.
- Decodes the port address, inserts CPU wait states until the selected device acknowledges, and returns read data.
- Times out unresponsive devices and keeps a saturating error count.
- Sits between tb_top's CPU I/O pins and the env-side I/O models.

---
 rtl/io_bus_ctl.sv | 144 ++++++++++++++
 tb/tb_io_bus_ctl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctl.sv
// Z80 I/O cycle sequencer: decodes the port address onto a req/ack device bus,
// holds the CPU in wait states until the device responds or times out.
module io_bus_ctl #(
  parameter int unsigned NDEV     = 4,
  parameter logic [3:0]  BASE_NIB = 4'h8,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  input  logic [7:0]           addr,
  input  logic [7:0]           DO,
  output logic [7:0]           DI,
  output logic                 di_oe,
  output logic                 wait_n,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_rd,
  output logic                 dev_wr,
  output logic [3:0]           dev_addr,
  output logic [7:0]           dev_wdata,
  input  logic [8*NDEV-1:0]    dev_rdata,
  input  logic [NDEV-1:0]      dev_ack,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nx;
  logic [7:0]        timer, timer_nx;
  logic [7:0]        di_nx, wdata_nx, err_nx;
  logic              oe_nx, wait_nx, rd_nx, wr_nx;
  logic [NDEV-1:0]   sel_nx;
  logic [3:0]        addr_nx;

  logic [4:0]        nib, base5;
  logic              hit, start, ack_hit, timeout;
  logic [2:0]        slot;
  logic [7:0]        rdata_sel, timer_inc;

  always_comb begin
    nib       = {1'b0, addr[7:4]};
    base5     = {1'b0, BASE_NIB};
    hit       = (nib >= base5) && (nib < (base5 + 5'(NDEV)));
    slot      = 3'(nib - base5);
    start     = !iorq_n && m1_n && (!rd_n || !wr_n) && hit;
    // dev_sel is one-hot while in REQ, so masking the acks rejects foreign slots
    ack_hit   = |(dev_ack & dev_sel);
    timer_inc = timer + 8'd1;
    timeout   = (timer_inc == 8'(TIMEOUT));
    rdata_sel = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (dev_sel[i]) rdata_sel = dev_rdata[i*8 +: 8];
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    di_nx    = DI;
    oe_nx    = di_oe;
    wait_nx  = wait_n;
    sel_nx   = dev_sel;
    rd_nx    = dev_rd;
    wr_nx    = dev_wr;
    addr_nx  = dev_addr;
    wdata_nx = dev_wdata;
    err_nx   = err_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = REQ;
          timer_nx = '0;
          for (int unsigned i = 0; i < NDEV; i++) sel_nx[i] = (32'(slot) == i);
          rd_nx    = !rd_n;
          wr_nx    = rd_n;
          wait_nx  = 1'b0;
          addr_nx  = addr[3:0];
          wdata_nx = DO;
        end
      end
      REQ: begin
        if (iorq_n) begin
          state_nx = IDLE;
          timer_nx = '0;
          sel_nx   = '0;
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          wait_nx  = 1'b1;
        end else if (ack_hit || timeout) begin
          state_nx = DONE;
          sel_nx   = '0;
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          wait_nx  = 1'b1;
          oe_nx    = dev_rd;
          if (dev_rd) di_nx = ack_hit ? rdata_sel : 8'hFF;
          if (!ack_hit && err_cnt != 8'hFF) err_nx = err_cnt + 8'd1;
        end else begin
          timer_nx = timer_inc;
        end
      end
      DONE: begin
        if (iorq_n) begin
          state_nx = IDLE;
          oe_nx    = 1'b0;
          timer_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      DI        <= '0;
      di_oe     <= 1'b0;
      wait_n    <= 1'b1;
      dev_sel   <= '0;
      dev_rd    <= 1'b0;
      dev_wr    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      DI        <= di_nx;
      di_oe     <= oe_nx;
      wait_n    <= wait_nx;
      dev_sel   <= sel_nx;
      dev_rd    <= rd_nx;
      dev_wr    <= wr_nx;
      dev_addr  <= addr_nx;
      dev_wdata <= wdata_nx;
      err_cnt   <= err_nx;
    end
  end

endmodule

// File: tb/tb_io_bus_ctl.sv
// Bench for io_bus_ctl: directed and randomized CPU I/O cycles against a
// cycle-count reference model of completion, timeout, data and error count.
module tb_io_bus_ctl;
  localparam int unsigned NDEV = 4;
  localparam logic [3:0]  BASE = 4'h8;
  localparam int unsigned TMO  = 15;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [7:0]          addr = '0, DO = '0;
  logic [7:0]          DI;
  logic                di_oe, wait_n, dev_rd, dev_wr;
  logic [NDEV-1:0]     dev_sel;
  logic [3:0]          dev_addr;
  logic [7:0]          dev_wdata, err_cnt;
  logic [8*NDEV-1:0]   dev_rdata = '0;
  logic [NDEV-1:0]     dev_ack = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // reference model of the held outputs
  logic [7:0] m_di = '0, m_addr = '0, m_wdata = '0, m_err = '0;

  io_bus_ctl #(.NDEV(NDEV), .BASE_NIB(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .addr(addr), .DO(DO), .DI(DI), .di_oe(di_oe),
    .wait_n(wait_n), .dev_sel(dev_sel), .dev_rd(dev_rd), .dev_wr(dev_wr),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
    .dev_ack(dev_ack), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string ph, input logic ew, input logic [NDEV-1:0] esel,
                            input logic erd, input logic ewr, input logic eoe);
    check({ph, ".wait_n"},    8'(wait_n),    8'(ew));
    check({ph, ".dev_sel"},   8'(dev_sel),   8'(esel));
    check({ph, ".dev_rd"},    8'(dev_rd),    8'(erd));
    check({ph, ".dev_wr"},    8'(dev_wr),    8'(ewr));
    check({ph, ".di_oe"},     8'(di_oe),     8'(eoe));
    check({ph, ".DI"},        DI,            m_di);
    check({ph, ".dev_addr"},  8'(dev_addr),  m_addr);
    check({ph, ".dev_wdata"}, dev_wdata,     m_wdata);
    check({ph, ".err_cnt"},   err_cnt,       m_err);
  endtask

  // One CPU I/O cycle. ack_at = REQ cycle in which the slot acks (>TMO: never);
  // abort_at = REQ cycle in which the CPU drops iorq_n (0: never).
  task automatic io_cycle(input logic [7:0] a, input logic rd, input logic wr, input logic m1,
                          input logic [7:0] d, input int unsigned ack_at,
                          input logic [NDEV-1:0] foreign, input int unsigned abort_at,
                          input logic [7:0] rdv);
    int n = int'(a[7:4]);
    int b = int'(BASE);
    logic mapped;
    logic [NDEV-1:0] sel = '0;
    int unsigned fin;
    logic timed, aborted;
    mapped = !m1 && (rd || wr) && (n >= b) && (n < b + int'(NDEV));
    if (mapped) sel[n - b] = 1'b1;
    for (int i = 0; i < int'(NDEV); i++)
      dev_rdata[i*8 +: 8] = (mapped && i == n - b) ? rdv : 8'($urandom);

    @(negedge clk);
    check_outs("idle", 1'b1, '0, 1'b0, 1'b0, 1'b0);
    iorq_n = 1'b0; rd_n = !rd; wr_n = !wr; m1_n = !m1; addr = a; DO = d;

    if (!mapped) begin
      repeat (3) begin
        @(negedge clk);
        check_outs("ignored", 1'b1, '0, 1'b0, 1'b0, 1'b0);
      end
    end else begin
      m_addr  = {4'h0, a[3:0]};
      m_wdata = d;
      fin     = (ack_at <= TMO) ? ack_at : TMO;
      timed   = ack_at > TMO;
      aborted = 1'b0;
      for (int unsigned k = 1; k <= fin; k++) begin
        @(negedge clk);
        check_outs("req", 1'b0, sel, rd, !rd, 1'b0);
        if (k == abort_at) begin
          iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; dev_ack = '0;
          aborted = 1'b1;
          break;
        end
        dev_ack = (foreign & ~sel) | ((k == ack_at) ? sel : '0);
      end
      if (aborted) begin
        @(negedge clk);
        check_outs("abort", 1'b1, '0, 1'b0, 1'b0, 1'b0);
      end else begin
        @(negedge clk);
        dev_ack = '0;
        if (rd) m_di = timed ? 8'hFF : rdv;
        if (timed && m_err != 8'hFF) m_err = m_err + 8'd1;
        check_outs("done", 1'b1, '0, 1'b0, 1'b0, rd);
        @(negedge clk);
        check_outs("hold", 1'b1, '0, 1'b0, 1'b0, rd);
      end
    end
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    @(negedge clk);
    check_outs("release", 1'b1, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] a;
    logic [1:0] rw;
    int unsigned ack_at, abort_at;

    repeat (2) @(negedge clk);
    check_outs("reset", 1'b1, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // write 0x5A to 0x81, ack in the 3rd REQ cycle
    io_cycle(8'h81, 1'b0, 1'b1, 1'b0, 8'h5A, 3, '0, 0, 8'h00);
    // read 0x93, immediate ack with 0x3C
    io_cycle(8'h93, 1'b1, 1'b0, 1'b0, 8'h11, 1, '0, 0, 8'h3C);
    // read 0xA2, never acks -> timeout, DI=FF, err 0->1
    io_cycle(8'hA2, 1'b1, 1'b0, 1'b0, 8'h22, TMO + 5, '0, 0, 8'h77);
    // unmapped read and interrupt acknowledge
    io_cycle(8'h40, 1'b1, 1'b0, 1'b0, 8'h33, 1, '0, 0, 8'h44);
    io_cycle(8'h80, 1'b1, 1'b0, 1'b1, 8'h33, 1, '0, 0, 8'h44);
    // read and write both low: read wins
    io_cycle(8'hB7, 1'b1, 1'b1, 1'b0, 8'h99, 2, '0, 0, 8'hC3);
    // foreign ack from slot 3 throughout, slot 0 acks exactly at the timeout cycle
    io_cycle(8'h85, 1'b1, 1'b0, 1'b0, 8'h00, TMO, 4'b1000, 0, 8'hE1);
    // CPU abort in REQ
    io_cycle(8'h96, 1'b0, 1'b1, 1'b0, 8'hAB, TMO + 1, '0, 4, 8'h00);

    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else a = {BASE + 4'($urandom_range(0, NDEV - 1)), 4'($urandom)};
      rw       = 2'($urandom);
      ack_at   = $urandom_range(1, TMO + 2);
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, TMO) : 0;
      io_cycle(a, rw[0], rw[1], ($urandom_range(0, 7) == 0), 8'($urandom), ack_at,
               NDEV'($urandom), abort_at, 8'($urandom));
    end

    // drive the error counter into saturation
    for (int r = 0; r < 300; r++)
      io_cycle(8'hA2, 1'b1, 1'b0, 1'b0, 8'h00, TMO + 1, '0, 0, 8'h55);
    check("err_cnt.saturated", err_cnt, 8'hFF);

    // asynchronous reset in the middle of a write to 0x82
    @(negedge clk);
    iorq_n = 1'b0; wr_n = 1'b0; addr = 8'h82; DO = 8'hC7;
    m_addr = 8'h02; m_wdata = 8'hC7;
    @(negedge clk);
    check_outs("pre_reset", 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    m_di = '0; m_addr = '0; m_wdata = '0; m_err = '0;
    check_outs("async_reset", 1'b1, '0, 1'b0, 1'b0, 1'b0);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    io_cycle(8'h82, 1'b0, 1'b1, 1'b0, 8'hC7, 2, '0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
